// File: rtl/tx_inband_pkg.sv
// ---------------------------------------------------------------------------
// tx_inband_pkg
//
// Purpose: definitions shared by the usbclk-side TX inband path. This package
//          holds the header word field positions, the payload size limit, the
//          command channel code and the packet state encoding.
//
// Ports:   none (package).
//
// Optional build macro: TX_CHAN_ROUTER_TIMESTAMP_EN. It is used by
// tx_chan_router and does not change anything in this package.
// ---------------------------------------------------------------------------
package tx_inband_pkg;

  // Header word 0 field positions
  localparam int LEN_MSB  = 8;
  localparam int LEN_LSB  = 0;
  localparam int CHAN_MSB = 20;
  localparam int CHAN_LSB = 16;
  localparam int SOB_BIT  = 28;
  localparam int EOB_BIT  = 27;

  localparam int LEN_W  = LEN_MSB - LEN_LSB + 1;
  localparam int CHAN_W = CHAN_MSB - CHAN_LSB + 1;

  // Words 2..127 carry payload: 126 words * 4 bytes
  localparam int MAX_PAYLOAD_BYTES = 504;
  localparam int CMD_CHAN_CODE     = 31;

  // 128-word packets, so the word counter wraps naturally at 127 -> 0
  localparam int WCNT_W = 7;
  localparam int PW_W   = 7;

  typedef logic [1:0] pkt_state_t;

  localparam logic [1:0] ST_HDR     = 2'd0;
  localparam logic [1:0] ST_TS      = 2'd1;
  localparam logic [1:0] ST_PAYLOAD = 2'd2;
  localparam logic [1:0] ST_DISCARD = 2'd3;

endpackage

// File: rtl/tx_hdr_decode.sv
// ---------------------------------------------------------------------------
// tx_hdr_decode
//
// Purpose: decodes the header fields of a packet without any registers. It
//          computes the payload word count and decides whether the packet's
//          target (a data channel or the command channel) can take the packet.
//
// Ports:
//   len_i          in  LEN_W     header length field, in bytes
//   chan_i         in  CHAN_W    header channel field
//   chan_space_i   in  NUM_CHAN  per-channel "room for one packet" flags
//   cmd_space_i    in  1         same flag for the command FIFO
//   pw_o           out PW_W      payload words, ceil(len/4)
//   is_cmd_o       out 1         channel field selects the command port
//   target_valid_o out 1         length legal and the target has room
//
// Optional build macro: TX_CHAN_ROUTER_TIMESTAMP_EN. It is not used here.
// With the macro defined, the space flags mean room for 127 words instead of
// 126. The check itself stays the same.
// ---------------------------------------------------------------------------
module tx_hdr_decode
  import tx_inband_pkg::*;
#(
  parameter int NUM_CHAN = 2,
  parameter int CMD_CHAN = CMD_CHAN_CODE
) (
  input  logic [LEN_W-1:0]    len_i,
  input  logic [CHAN_W-1:0]   chan_i,
  input  logic [NUM_CHAN-1:0] chan_space_i,
  input  logic                cmd_space_i,
  output logic [PW_W-1:0]     pw_o,
  output logic                is_cmd_o,
  output logic                target_valid_o
);

  logic [NUM_CHAN-1:0] chan_hit;
  logic                len_ok;

  // ceil(len/4). Only len > 508 overflows 7 bits, and that length is
  // rejected by len_ok anyway.
  assign pw_o = len_i[LEN_W-1:2] + {{(PW_W-1){1'b0}}, |len_i[1:0]};

  assign len_ok   = (len_i <= LEN_W'(MAX_PAYLOAD_BYTES));
  assign is_cmd_o = (chan_i == CHAN_W'(CMD_CHAN));

  // A channel code at or above NUM_CHAN matches no hit bit, so it can only
  // be valid as the command channel.
  for (genvar gi = 0; gi < NUM_CHAN; gi++) begin : g_hit
    assign chan_hit[gi] = (chan_i == CHAN_W'(gi)) && chan_space_i[gi];
  end

  assign target_valid_o = len_ok && ((|chan_hit) || (is_cmd_o && cmd_space_i));

endmodule

// File: rtl/tx_chan_router.sv
// ---------------------------------------------------------------------------
// tx_chan_router
//
// Purpose: packet-level router on the usbclk side of the TX inband path.
//          It takes 128-word (512-byte) USB packets one word per in_wr. It
//          parses header word 0 and sends the payload words to one of the
//          NUM_CHAN data FIFOs or to the command FIFO. Packets that are
//          malformed, or whose target has no room, are dropped and counted.
//
// Ports:
//   usbclk      in  1         clock
//   reset       in  1         synchronous active-high reset
//   in_wr       in  1         in_data valid strobe
//   in_data     in  32        packed USB word
//   chan_space  in  NUM_CHAN  data FIFO can take a full packet payload
//   cmd_space   in  1         command FIFO can take a full packet payload
//   chan_wr     out NUM_CHAN  one-hot data FIFO write strobe
//   cmd_wr      out 1         command FIFO write strobe
//   out_data    out 32        write data
//   out_sop     out 1         first word written for the packet
//   out_eop     out 1         last word written for the packet
//   pkt_active  out 1         a packet is in progress (state != HDR)
//   drop_count  out 16        saturating count of dropped packets
//
// Optional build macro: TX_CHAN_ROUTER_TIMESTAMP_EN.
//   Defined:   the timestamp word (word 1) is written first and carries
//              out_sop. A zero-length packet then writes only the timestamp,
//              with out_sop and out_eop both set.
//   Undefined: the timestamp is discarded. out_sop marks the first payload
//              word.
// ---------------------------------------------------------------------------
module tx_chan_router
  import tx_inband_pkg::*;
#(
  parameter int NUM_CHAN  = 2,
  parameter int PKT_WORDS = 128,
  parameter int CMD_CHAN  = CMD_CHAN_CODE
) (
  input  logic                usbclk,
  input  logic                reset,
  input  logic                in_wr,
  input  logic [31:0]         in_data,
  input  logic [NUM_CHAN-1:0] chan_space,
  input  logic                cmd_space,
  output logic [NUM_CHAN-1:0] chan_wr,
  output logic                cmd_wr,
  output logic [31:0]         out_data,
  output logic                out_sop,
  output logic                out_eop,
  output logic                pkt_active,
  output logic [15:0]         drop_count
);

  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(PKT_WORDS - 1);

  // Packet tracking state
  pkt_state_t        state_q,    state_d;
  logic [WCNT_W-1:0] wcnt_q,     wcnt_d;
  logic [PW_W-1:0]   rem_q,      rem_d;
  logic [CHAN_W-1:0] chan_q,     chan_d;
  logic              is_cmd_q,   is_cmd_d;
  logic              sop_pend_q, sop_pend_d;
  logic [15:0]       drop_q,     drop_d;

  // Registered write port
  logic [NUM_CHAN-1:0] chan_wr_q, chan_wr_d;
  logic                cmd_wr_q,  cmd_wr_d;
  logic [31:0]         data_q,    data_d;
  logic                sop_q,     sop_d;
  logic                eop_q,     eop_d;

  logic wr_en;

  // Header decode, used only while state is HDR
  logic [PW_W-1:0] hdr_pw;
  logic            hdr_is_cmd;
  logic            hdr_valid;

  tx_hdr_decode #(
    .NUM_CHAN (NUM_CHAN),
    .CMD_CHAN (CMD_CHAN)
  ) u_hdr_decode (
    .len_i          (in_data[LEN_MSB:LEN_LSB]),
    .chan_i         (in_data[CHAN_MSB:CHAN_LSB]),
    .chan_space_i   (chan_space),
    .cmd_space_i    (cmd_space),
    .pw_o           (hdr_pw),
    .is_cmd_o       (hdr_is_cmd),
    .target_valid_o (hdr_valid)
  );

  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    rem_d      = rem_q;
    chan_d     = chan_q;
    is_cmd_d   = is_cmd_q;
    sop_pend_d = sop_pend_q;
    drop_d     = drop_q;
    wr_en      = 1'b0;
    sop_d      = 1'b0;
    eop_d      = 1'b0;

    if (in_wr) begin
      wcnt_d = wcnt_q + WCNT_W'(1);

      case (state_q)
        ST_HDR: begin
          chan_d   = in_data[CHAN_MSB:CHAN_LSB];
          is_cmd_d = hdr_is_cmd;
          rem_d    = hdr_pw;
          if (hdr_valid) begin
            state_d = ST_TS;
          end else begin
            state_d = ST_DISCARD;
            if (drop_q != 16'hFFFF) begin
              drop_d = drop_q + 16'd1;
            end
          end
        end

        ST_TS: begin
`ifdef TX_CHAN_ROUTER_TIMESTAMP_EN
          wr_en      = 1'b1;
          sop_d      = 1'b1;
          eop_d      = (rem_q == '0);
          sop_pend_d = 1'b0;
`else
          // The first payload word carries sop
          sop_pend_d = 1'b1;
`endif
          // Zero-length packets are legal. They are swallowed without
          // counting a drop.
          state_d = (rem_q != '0) ? ST_PAYLOAD : ST_DISCARD;
        end

        ST_PAYLOAD: begin
          wr_en      = 1'b1;
          sop_d      = sop_pend_q;
          sop_pend_d = 1'b0;
          rem_d      = rem_q - PW_W'(1);
          if (rem_q == PW_W'(1)) begin
            eop_d   = 1'b1;
            state_d = ST_DISCARD;
          end
        end

        default: begin
          // DISCARD: swallow words until the word counter wraps
        end
      endcase

      // The word counter wrap realigns to the next header in every state. The
      // longest payload ends exactly on word 127, so no write is cut off.
      if (wcnt_q == WCNT_LAST) begin
        state_d = ST_HDR;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_CHAN; gi++) begin : g_chan_wr
    assign chan_wr_d[gi] = wr_en && !is_cmd_q && (chan_q == CHAN_W'(gi));
  end

  assign cmd_wr_d = wr_en && is_cmd_q;
  assign data_d   = wr_en ? in_data : data_q;

  always_ff @(posedge usbclk) begin
    if (reset) begin
      state_q    <= ST_HDR;
      wcnt_q     <= '0;
      rem_q      <= '0;
      chan_q     <= '0;
      is_cmd_q   <= 1'b0;
      sop_pend_q <= 1'b0;
      drop_q     <= '0;
      chan_wr_q  <= '0;
      cmd_wr_q   <= 1'b0;
      data_q     <= '0;
      sop_q      <= 1'b0;
      eop_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      rem_q      <= rem_d;
      chan_q     <= chan_d;
      is_cmd_q   <= is_cmd_d;
      sop_pend_q <= sop_pend_d;
      drop_q     <= drop_d;
      chan_wr_q  <= chan_wr_d;
      cmd_wr_q   <= cmd_wr_d;
      data_q     <= data_d;
      sop_q      <= sop_d;
      eop_q      <= eop_d;
    end
  end

  assign chan_wr    = chan_wr_q;
  assign cmd_wr     = cmd_wr_q;
  assign out_data   = data_q;
  assign out_sop    = sop_q;
  assign out_eop    = eop_q;
  assign pkt_active = (state_q != ST_HDR);
  assign drop_count = drop_q;

endmodule

// File: tb/tb_tx_chan_router.sv
// ---------------------------------------------------------------------------
// tb_tx_chan_router
//
// Directed testbench for tx_chan_router. A packet-level model predicts which
// words of each packet must come out, and where sop and eop fall. The model
// works from the header fields, the space flags sampled at the header, and
// the word index. Every cycle the DUT outputs are compared with the
// prediction. Literal counts of writes and drops pin the model.
//
// Optional build macro: TX_CHAN_ROUTER_TIMESTAMP_EN. When it is defined, the
// timestamp word is expected as an extra first write.
// ---------------------------------------------------------------------------
module tb_tx_chan_router;

  localparam int NUM_CHAN = 2;
`ifdef TX_CHAN_ROUTER_TIMESTAMP_EN
  localparam int TS_WORDS = 1;
`else
  localparam int TS_WORDS = 0;
`endif

  logic                usbclk     = 1'b0;
  logic                reset      = 1'b1;
  logic                in_wr      = 1'b0;
  logic [31:0]         in_data    = '0;
  logic [NUM_CHAN-1:0] chan_space = '0;
  logic                cmd_space  = 1'b0;
  logic [NUM_CHAN-1:0] chan_wr;
  logic                cmd_wr;
  logic [31:0]         out_data;
  logic                out_sop;
  logic                out_eop;
  logic                pkt_active;
  logic [15:0]         drop_count;

  tx_chan_router #(
    .NUM_CHAN  (NUM_CHAN),
    .PKT_WORDS (128),
    .CMD_CHAN  (31)
  ) dut (
    .usbclk     (usbclk),
    .reset      (reset),
    .in_wr      (in_wr),
    .in_data    (in_data),
    .chan_space (chan_space),
    .cmd_space  (cmd_space),
    .chan_wr    (chan_wr),
    .cmd_wr     (cmd_wr),
    .out_data   (out_data),
    .out_sop    (out_sop),
    .out_eop    (out_eop),
    .pkt_active (pkt_active),
    .drop_count (drop_count)
  );

  always #5 usbclk = ~usbclk;

  // Expected outputs caused by the inputs now being driven (p_*). They are
  // moved to exp_* on the clock edge that consumes those inputs.
  logic [NUM_CHAN-1:0] p_chan_wr = '0, exp_chan_wr;
  logic                p_cmd_wr  = 1'b0, exp_cmd_wr;
  logic [31:0]         p_data    = '0, exp_data;
  logic                p_sop     = 1'b0, exp_sop;
  logic                p_eop     = 1'b0, exp_eop;
  logic                p_active  = 1'b0, exp_active;
  logic [15:0]         p_drop    = '0, exp_drop;

  always @(posedge usbclk) begin
    exp_chan_wr <= p_chan_wr;
    exp_cmd_wr  <= p_cmd_wr;
    exp_data    <= p_data;
    exp_sop     <= p_sop;
    exp_eop     <= p_eop;
    exp_active  <= p_active;
    exp_drop    <= p_drop;
  end

  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  int   n_chan0 = 0, n_chan1 = 0, n_cmd = 0;
  int   model_drop = 0;
  logic model_active = 1'b0;

  task automatic check_cycle();
    tests++;
    if (chan_wr !== exp_chan_wr || cmd_wr !== exp_cmd_wr || out_sop !== exp_sop ||
        out_eop !== exp_eop || pkt_active !== exp_active || drop_count !== exp_drop ||
        ((exp_cmd_wr || exp_chan_wr != '0) && out_data !== exp_data)) begin
      fails++;
      $display("FAIL cycle_check cyc=%0d got wr=%b cmd=%b data=%h sop=%b eop=%b act=%b drop=%0d want wr=%b cmd=%b data=%h sop=%b eop=%b act=%b drop=%0d",
               cyc, chan_wr, cmd_wr, out_data, out_sop, out_eop, pkt_active, drop_count,
               exp_chan_wr, exp_cmd_wr, exp_data, exp_sop, exp_eop, exp_active, exp_drop);
    end
    if (chan_wr[0] === 1'b1) n_chan0++;
    if (chan_wr[1] === 1'b1) n_chan1++;
    if (cmd_wr === 1'b1) n_cmd++;
  endtask

  task automatic pin(input string name, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  // Drive one cycle of inputs with its predicted outputs, then check them
  task automatic cycle(input logic wr, input logic [31:0] d, input logic [NUM_CHAN-1:0] pcw,
                       input logic pcmd, input logic psop, input logic peop);
    in_wr     = wr;
    in_data   = d;
    p_chan_wr = pcw;
    p_cmd_wr  = pcmd;
    p_data    = d;
    p_sop     = psop;
    p_eop     = peop;
    p_active  = model_active;
    p_drop    = 16'(model_drop);
    @(negedge usbclk);
    cyc++;
    check_cycle();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    model_drop   = 0;
    model_active = 1'b0;
    idle(2);
    reset = 1'b0;
  endtask

  // Send words 0..nwords-1 of a packet, with random idle gaps of up to
  // max_gap cycles before each word. If clear_space is set, the space flags
  // drop after the header and are restored when the packet ends.
  task automatic send_pkt(input int ch, input int len, input logic [31:0] base,
                          input int nwords, input int max_gap, input bit clear_space);
    logic [31:0]         hdr;
    logic [31:0]         d;
    logic [NUM_CHAN-1:0] saved_space;
    logic [NUM_CHAN-1:0] pcw;
    bit                  valid, w;
    int                  pw, first, last;

    // Ignored header bits (sob, eob and the unused bits) are all set
    hdr = 32'hFFE0_FE00 | (32'(ch) << 16) | 32'(len);
    valid = 1'b0;
    if (len <= 504) begin
      if (ch < NUM_CHAN) valid = chan_space[ch];
      else if (ch == 31) valid = cmd_space;
    end
    pw    = (len + 3) / 4;
    first = 2 - TS_WORDS;
    last  = 1 + pw;
    saved_space = chan_space;

    for (int k = 0; k < nwords; k++) begin
      idle(int'($urandom_range(0, max_gap)));
      if (k == 0) d = hdr;
      else if (k == 1) d = base ^ 32'h7500_0000;
      else d = base + 32'(k);
      if (k == 0 && !valid && model_drop < 65535) model_drop++;
      w   = valid && k >= first && k <= last && (pw > 0 || TS_WORDS == 1);
      pcw = '0;
      if (w && ch < NUM_CHAN) pcw = NUM_CHAN'(1 << ch);
      model_active = (k != 127);
      cycle(1'b1, d, pcw, w && ch == 31, w && k == first, w && k == last);
      if (k == 0 && clear_space) chan_space = '0;
    end
    chan_space = saved_space;
  endtask

  int c0, c1, cc;

  initial begin
    // Reset state: outputs are compared with all-zero expectations
    do_reset();
    pin("reset_drop", int'(drop_count), 0);
    pin("reset_active", int'(pkt_active), 0);

    // Channel 0, 16 bytes: 4 payload words, back-to-back timing
    chan_space = 2'b11;
    cmd_space  = 1'b1;
    c0 = n_chan0;
    send_pkt(0, 16, 32'h1000_0000, 128, 0, 1'b0);
    idle(1);
    pin("t1_chan0_writes", n_chan0 - c0, 4 + TS_WORDS);
    pin("t1_drop", int'(drop_count), 0);

    // Channel 1 has no room: the packet is dropped, then channel 0 routes
    chan_space = 2'b01;
    c1 = n_chan1;
    send_pkt(1, 16, 32'h2000_0000, 128, 0, 1'b0);
    pin("t2_chan1_writes", n_chan1 - c1, 0);
    pin("t2_drop", int'(drop_count), 1);
    c0 = n_chan0;
    send_pkt(0, 20, 32'h3000_0000, 128, 2, 1'b0);
    idle(1);
    pin("t2_chan0_writes", n_chan0 - c0, 5 + TS_WORDS);

    // Command channel, 4 bytes: a single word with sop and eop both set
    chan_space = 2'b11;
    cc = n_cmd;
    c0 = n_chan0;
    send_pkt(31, 4, 32'h4000_0000, 128, 1, 1'b0);
    idle(1);
    pin("t3_cmd_writes", n_cmd - cc, 1 + TS_WORDS);
    pin("t3_chan0_writes", n_chan0 - c0, 0);

    // Bad length, then a channel beyond NUM_CHAN: both dropped
    send_pkt(0, 505, 32'h5000_0000, 128, 0, 1'b0);
    send_pkt(5, 16, 32'h5100_0000, 128, 0, 1'b0);
    pin("t4_drop", int'(drop_count), 3);

    // Zero length is legal: nothing written and no drop
    c0 = n_chan0;
    send_pkt(0, 0, 32'h6000_0000, 128, 0, 1'b0);
    pin("t4_len0_writes", n_chan0 - c0, TS_WORDS);
    pin("t4_len0_drop", int'(drop_count), 3);

    // Largest payload: 504 bytes, last word on word 127, then back-to-back
    c1 = n_chan1;
    send_pkt(1, 504, 32'h7000_0000, 128, 0, 1'b0);
    // 5 bytes -> 2 words. Space is removed mid-packet and must not abort.
    send_pkt(1, 5, 32'h8000_0000, 128, 1, 1'b1);
    idle(1);
    pin("t4_chan1_writes", n_chan1 - c1, 126 + 2 + 2 * TS_WORDS);

    // Reset at word 40 of a 200-byte packet, then a fresh 8-byte packet
    send_pkt(0, 200, 32'h9000_0000, 40, 0, 1'b0);
    do_reset();
    pin("t5_drop_after_reset", int'(drop_count), 0);
    c0 = n_chan0;
    c1 = n_chan1;
    send_pkt(1, 8, 32'hA000_0000, 128, 0, 1'b0);
    idle(2);
    pin("t5_chan1_writes", n_chan1 - c1, 2 + TS_WORDS);
    pin("t5_chan0_writes", n_chan0 - c0, 0);
    pin("t5_active_idle", int'(pkt_active), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tx_chan_router.md
Name: tx_chan_router

Overview:
- Packet-level controller on the usbclk side of the TX inband path.
- Consumes the 32-bit packed word stream (one word per in_wr strobe) that makes up fixed 512-byte USB packets (128 words).
- Parses each packet header and routes the payload words to one of NUM_CHAN per-channel TX FIFOs, or to the command channel.
- Drops packets that are malformed or whose target lacks space, and reports the drop count.

Parameters:
- NUM_CHAN, 2, number of TX data channels (1..8).
- PKT_WORDS, 128, 32-bit words per USB packet.
- CMD_CHAN, 31, header channel code routed to the command port.

Ports:
- usbclk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- in_wr  in  1  one-cycle strobe; in_data is valid.
- in_data  in  32  packed USB word.
- chan_space  in  NUM_CHAN  per-channel flag: FIFO can accept one full packet payload (126 words).
- cmd_space  in  1  same meaning for the command FIFO.
- chan_wr  out  NUM_CHAN  one-hot write strobe to the data FIFOs.
- cmd_wr  out  1  write strobe to the command FIFO.
- out_data  out  32  word for chan_wr/cmd_wr.
- out_sop  out  1  marks the first word written for a packet.
- out_eop  out  1  marks the last word written for a packet.
- pkt_active  out  1  high while a packet is being accepted (state != HDR).
- drop_count  out  16  saturating count of dropped packets.

Behaviour:
- Reset: all outputs 0; state=HDR; word counter=0; drop_count=0.
- Header word 0 fields:
  - [8:0] payload length in bytes, len.
  - [20:16] channel.
  - [28] start-of-burst.
  - [27] end-of-burst.
  - Other bits ignored.
- Word 1 is the timestamp. Words 2..127 are the payload region.
- Word counter wcnt (7 bits) increments on each in_wr and wraps 127->0. When wcnt wraps, state returns to HDR regardless of the current state.
- States: HDR, TS, PAYLOAD, DISCARD.
  - HDR, on in_wr: latch len and channel; compute pw = ceil(len/4).
    - Target valid when channel<NUM_CHAN and chan_space[channel]=1, or channel==CMD_CHAN and cmd_space=1.
    - Also requires len<=504.
    - If target valid, go to TS. Otherwise go to DISCARD and increment drop_count (saturates at 0xFFFF).
  - TS, on in_wr: go to PAYLOAD if pw>0. Otherwise go to DISCARD, with no drop increment (an empty packet is legal).
  - PAYLOAD, on in_wr: write in_data to the target and decrement the remaining count. On the last payload word, assert out_eop and go to DISCARD.
  - DISCARD: swallow words until wcnt wraps.
- Output timing: writes are registered, so chan_wr/cmd_wr/out_data/out_sop/out_eop appear exactly one cycle after the causing in_wr. Strobes are one cycle wide.
- out_sop and out_eop are both high when pw==1.
- chan_space/cmd_space are sampled only in HDR. Deassertion mid-packet does not abort the packet; the FIFO guarantees 126 words of room.
- in_wr gaps of any length are tolerated; state holds.
- Reset mid-packet: discard the partial packet; the next word is treated as a header. The upstream bus_reset realigns the stream.
- Back-to-back packets with no gap: the header on the cycle after word 127 is accepted.

Optional Feature:
- TX_CHAN_ROUTER_TIMESTAMP_EN.
- Defined: the TS word is written to the target as the first output word with out_sop=1. Payload follows; the payload's first word has out_sop=0. The space check requires room for 127 words.
- Undefined: the timestamp is discarded and out_sop marks the first payload word.

Decomposition:
- Shared package tx_inband_pkg holds:
  - Header field bit positions (LEN_MSB/LSB, CHAN_MSB/LSB, SOB_BIT, EOB_BIT).
  - MAX_PAYLOAD_BYTES=504, CMD_CHAN_CODE=31.
  - State encoding.
- One natural sub-module, tx_hdr_decode: combinational field extraction, pw computation and target validity check.

Test Plan:
- Header chan=0, len=16, chan_space=2'b11; full 128-word packet -> 4 chan_wr[0] pulses carrying words 2..5; sop on word 2, eop on word 5, each one cycle after its in_wr; drop_count=0.
- Header chan=1, chan_space=2'b01 -> no writes; drop_count=1; the following packet to chan 0 routes normally.
- Header chan=31, len=4, cmd_space=1 -> one cmd_wr with out_sop=out_eop=1; chan_wr stays 0.
- len=505 or chan=5 (NUM_CHAN=2) -> packet dropped, drop_count increments; len=0 -> no writes and no drop.
- Reset asserted at word 40 of a packet, then a new packet -> the new header is decoded correctly and no stale writes occur.
- 0xFFFF+2 rejected packets -> drop_count saturates at 0xFFFF; with TX_CHAN_ROUTER_TIMESTAMP_EN, len=8 yields 3 writes: timestamp with sop, then 2 payload words.
